// File: rtl/ledtoggle_blink_sequencer.sv
// ---------------------------------------------------------------------------
// ledtoggle_blink_sequencer
//
// This block blinks an LED using the system interval timer, so no CPU is
// needed. It acts as an Avalon-MM write-only master on the timer's s1 port.
// For each LED phase it:
//   - writes the 32-bit period through the two 16-bit period registers,
//   - starts the timer in one-shot mode with the interrupt enabled,
//   - waits for the timeout IRQ,
//   - clears the status register,
//   - toggles the LED.
// The on and off phases alternate for the programmed number of on/off pairs.
// A repeat count of zero means the block runs until it is stopped.
//
// Ports
//   clk, reset       system clock (shared with the timer); async active-high
//                    reset
//   start            one-cycle request, honoured only in IDLE
//   stop             one-cycle abort, honoured in any non-IDLE state
//   on_period        LED-on phase length in clk cycles; latched at start
//   off_period       LED-off phase length in clk cycles; latched at start
//   repeat_count     on/off pairs to run (0 = forever); latched at start
//   led              LED drive
//   busy             high from the accepted start until the return to IDLE
//   done             one-cycle pulse when all pairs complete
//   toggle_count     LED toggles since the last accepted start (wraps)
//   tmr_address      timer register index (write master)
//   tmr_chipselect   timer register select (write master)
//   tmr_write_n      active-low write strobe (write master)
//   tmr_writedata    timer write data (write master)
//   tmr_irq          timer timeout interrupt, level
//
// All outputs are registered. The bus registers are loaded from the
// next-state value, so each write appears in the same cycle as the state
// that issues it.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for start; bus idle
// WR_PL      | write period[15:0] to period_l
// WR_PH      | write period[31:16] to period_h
// SETTLE     | one idle bus cycle for the timer's reload / self-stop
// WR_CTRL    | write START|ITO (one-shot) to control
// WAIT_IRQ   | wait for the timeout interrupt
// CLR_ST     | write status to clear the timeout
// TOGGLE     | invert LED, count toggle, pick next phase or finish
// ABORT_STOP | write STOP to control
// ABORT_CLR  | clear status, then return to IDLE with LED off
// ---------------------------------------------------------------------------
module ledtoggle_blink_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [31:0]      on_period,
    input  logic [31:0]      off_period,
    input  logic [CNT_W-1:0] repeat_count,
    output logic             led,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] toggle_count,
    output logic [2:0]       tmr_address,
    output logic             tmr_chipselect,
    output logic             tmr_write_n,
    output logic [15:0]      tmr_writedata,
    input  logic             tmr_irq
);

    // Timer register map and control words.
    localparam logic [2:0]  ADDR_STATUS    = 3'd0;
    localparam logic [2:0]  ADDR_CONTROL   = 3'd1;
    localparam logic [2:0]  ADDR_PERIOD_L  = 3'd2;
    localparam logic [2:0]  ADDR_PERIOD_H  = 3'd3;
    localparam logic [15:0] CTRL_START_ITO = 16'h0005;
    localparam logic [15:0] CTRL_STOP      = 16'h0008;
    localparam logic [15:0] STATUS_CLEAR   = 16'h0000;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_WR_PL      = 4'd1,
        ST_WR_PH      = 4'd2,
        ST_SETTLE     = 4'd3,
        ST_WR_CTRL    = 4'd4,
        ST_WAIT_IRQ   = 4'd5,
        ST_CLR_ST     = 4'd6,
        ST_TOGGLE     = 4'd7,
        ST_ABORT_STOP = 4'd8,
        ST_ABORT_CLR  = 4'd9
    } state_t;

    // The timer counts period+1 cycles. A zero-length phase is treated as
    // a one-cycle phase, so zero never underflows to 0xFFFF_FFFF.
    function automatic logic [31:0] period_of(input logic [31:0] len);
        return (len == 32'd0) ? 32'd0 : (len - 32'd1);
    endfunction

    state_t           state_q, state_d;

    logic             led_q, led_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [CNT_W-1:0] pair_q, pair_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [31:0]      on_q, on_d;
    logic [31:0]      off_q, off_d;
    logic [31:0]      period_q, period_d;

    logic             cs_q, cs_d;
    logic             wn_q, wn_d;
    logic [2:0]       addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;

    logic             start_acc;
    logic             abort_req;
    logic             toggle_en;
    logic             pair_done;
    logic [CNT_W-1:0] pair_inc;

    // Event decode
    assign start_acc = (state_q == ST_IDLE) && start && !stop;

    // stop is ignored in IDLE. It is also ignored while the abort sequence
    // is already running.
    assign abort_req = stop
                       && (state_q != ST_IDLE)
                       && (state_q != ST_ABORT_STOP)
                       && (state_q != ST_ABORT_CLR);

    // stop takes priority over a pending toggle.
    assign toggle_en = (state_q == ST_TOGGLE) && !stop;

    assign pair_inc  = pair_q + CNT_W'(1);

    // A pair completes when the LED goes back on, that is, when it is off
    // now and is about to be inverted.
    assign pair_done = toggle_en && !led_q
                       && (rep_q != '0) && (pair_inc == rep_q);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (abort_req) begin
            state_d = ST_ABORT_STOP;
        end else begin
            case (state_q)
                ST_IDLE:       if (start_acc) state_d = ST_WR_PL;
                ST_WR_PL:      state_d = ST_WR_PH;
                ST_WR_PH:      state_d = ST_SETTLE;
                ST_SETTLE:     state_d = ST_WR_CTRL;
                ST_WR_CTRL:    state_d = ST_WAIT_IRQ;
                ST_WAIT_IRQ:   if (tmr_irq) state_d = ST_CLR_ST;
                ST_CLR_ST:     state_d = ST_TOGGLE;
                ST_TOGGLE:     state_d = pair_done ? ST_IDLE : ST_WR_PL;
                ST_ABORT_STOP: state_d = ST_ABORT_CLR;
                ST_ABORT_CLR:  state_d = ST_IDLE;
                default:       state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic: datapath next values and bus cycle for the next state
    always_comb begin
        led_d    = led_q;
        tcnt_d   = tcnt_q;
        pair_d   = pair_q;
        rep_d    = rep_q;
        on_d     = on_q;
        off_d    = off_q;
        period_d = period_q;
        done_d   = 1'b0;
        busy_d   = (state_d != ST_IDLE);

        if (start_acc) begin
            on_d     = on_period;
            off_d    = off_period;
            rep_d    = repeat_count;
            led_d    = 1'b1;
            tcnt_d   = '0;
            pair_d   = '0;
            period_d = period_of(on_period);
        end

        if (toggle_en) begin
            led_d  = ~led_q;
            tcnt_d = tcnt_q + CNT_W'(1);
            done_d = pair_done;
            if (led_q) begin
                period_d = period_of(off_q);
            end else begin
                pair_d   = pair_inc;
                period_d = period_of(on_q);
            end
        end

        // The LED turns off when the abort sequence returns to IDLE.
        // toggle_count keeps its value.
        if (state_q == ST_ABORT_CLR) begin
            led_d = 1'b0;
        end

        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = ADDR_STATUS;
        wdata_d = 16'h0000;
        case (state_d)
            ST_WR_PL: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = ADDR_PERIOD_L;
                wdata_d = period_d[15:0];
            end
            ST_WR_PH: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = ADDR_PERIOD_H;
                wdata_d = period_d[31:16];
            end
            ST_WR_CTRL: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = ADDR_CONTROL;
                wdata_d = CTRL_START_ITO;
            end
            ST_CLR_ST, ST_ABORT_CLR: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = ADDR_STATUS;
                wdata_d = STATUS_CLEAR;
            end
            ST_ABORT_STOP: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = ADDR_CONTROL;
                wdata_d = CTRL_STOP;
            end
            default: begin
                cs_d    = 1'b0;
                wn_d    = 1'b1;
                addr_d  = ADDR_STATUS;
                wdata_d = 16'h0000;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tcnt_q   <= '0;
            pair_q   <= '0;
            rep_q    <= '0;
            on_q     <= 32'd0;
            off_q    <= 32'd0;
            period_q <= 32'd0;
            cs_q     <= 1'b0;
            wn_q     <= 1'b1;
            addr_q   <= 3'd0;
            wdata_q  <= 16'h0000;
        end else begin
            led_q    <= led_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tcnt_q   <= tcnt_d;
            pair_q   <= pair_d;
            rep_q    <= rep_d;
            on_q     <= on_d;
            off_q    <= off_d;
            period_q <= period_d;
            cs_q     <= cs_d;
            wn_q     <= wn_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign led            = led_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign toggle_count   = tcnt_q;
    assign tmr_chipselect = cs_q;
    assign tmr_write_n    = wn_q;
    assign tmr_address    = addr_q;
    assign tmr_writedata  = wdata_q;

endmodule
